// File: rtl/randn_pkg.sv
// Shared definitions for the randn generator and checker.
// Holds the FSM encoding plus the LFSR step and sign-extension helpers.
package randn_pkg;

  // Widest LFSR state and sample the helpers accept; callers slice results.
  localparam int MAX_N   = 32;
  localparam int MAX_BUF = 64;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Galois step: the feedback bit s[0] lands in the top bit and is XORed into the tapped lower bits.
  function automatic logic [MAX_N-1:0] lfsr_step(input logic [MAX_N-1:0] s,
                                                 input logic [MAX_N-1:0] poly,
                                                 input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N - 1; i++) begin
      if (i < n - 1) r[i] = (s[0] & poly[i]) ^ s[i+1];
    end
    r[n-1] = s[0];
    return r;
  endfunction

  function automatic logic [MAX_BUF-1:0] sign_ext(input logic [MAX_N-1:0] s, input int n);
    logic [MAX_BUF-1:0] r;
    r = {MAX_BUF{s[n-1]}};
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) r[i] = s[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a simultaneous increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         init,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge init) begin
    if (init)                      count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && count != '1)   count <= count + 1'b1;
  end

endmodule

// File: rtl/randn_checker.sv
// Receive-side checker for the randn LFSR stream: self-seeds from well-formed samples,
// locks after LOCK_COUNT correct predictions, then flywheels and counts mismatches.
module randn_checker
  import randn_pkg::*;
#(
  parameter int n           = 2,
  parameter int buffer_size = 16,
  parameter int LOCK_COUNT  = 8,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic                   clk,
  input  logic                   init,
  input  logic                   en,
  input  logic [n-1:0]           poly,
  input  logic [buffer_size-1:0] D,
  input  logic                   clr_cnt,
  output logic                   locked,
  output logic                   err_pulse,
  output logic [ERR_W-1:0]       err_count,
  output logic [ERR_W-1:0]       sample_count
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_THRESH + 1);

  if (buffer_size < n + 1 || n >= MAX_N || buffer_size >= MAX_BUF ||
      LOCK_COUNT < 1 || LOSS_THRESH < 1) begin : g_param_check
    $error("randn_checker: illegal parameter combination");
  end

  state_t           state, state_next;
  logic [n-1:0]     pred, pred_d;
  logic [GW-1:0]    good_cnt, good_d;
  logic [BW-1:0]    bad_cnt, bad_d;
  logic             err_d, err_inc, sample_inc;

  logic [MAX_N-1:0]   poly_w, pred_w, seed_w, step_pred_w, step_seed_w;
  logic [MAX_BUF-1:0] ext_pred_w, ext_seed_w;
  logic [n-1:0]       step_pred, step_seed;
  logic               match, well_formed, lock_hit, loss_hit;
  logic               unused_ok;

  assign poly_w = {{(MAX_N-n){1'b0}}, poly};
  assign pred_w = {{(MAX_N-n){1'b0}}, pred};
  assign seed_w = {{(MAX_N-n){1'b0}}, D[n-1:0]};

  assign step_pred_w = lfsr_step(pred_w, poly_w, n);
  assign step_seed_w = lfsr_step(seed_w, poly_w, n);
  assign ext_pred_w  = sign_ext(pred_w, n);
  assign ext_seed_w  = sign_ext(seed_w, n);
  assign step_pred   = step_pred_w[n-1:0];
  assign step_seed   = step_seed_w[n-1:0];

  // A sample is well formed when it is its own sign extension and non-zero (zero is a fixed point).
  assign match       = (D == ext_pred_w[buffer_size-1:0]);
  assign well_formed = (D == ext_seed_w[buffer_size-1:0]) && (D[n-1:0] != '0);
  assign lock_hit    = (good_cnt == GW'(LOCK_COUNT - 1));
  assign loss_hit    = (bad_cnt == BW'(LOSS_THRESH - 1));

  assign unused_ok = ^{step_pred_w[MAX_N-1:n], step_seed_w[MAX_N-1:n],
                       ext_pred_w[MAX_BUF-1:buffer_size], ext_seed_w[MAX_BUF-1:buffer_size]};

  always_ff @(posedge clk or posedge init) begin
    if (init) state <= HUNT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (en) begin
      case (state)
        HUNT:    if (well_formed) state_next = ACQUIRE;
        ACQUIRE: begin
          if (match) begin
            if (lock_hit) state_next = LOCKED;
          end else if (!well_formed) begin
            state_next = HUNT;
          end
        end
        LOCKED:  if (!match && loss_hit) state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    pred_d     = pred;
    good_d     = good_cnt;
    bad_d      = bad_cnt;
    err_d      = 1'b0;
    err_inc    = 1'b0;
    sample_inc = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (well_formed) begin
            pred_d = step_seed;
            good_d = '0;
          end
        end
        ACQUIRE: begin
          if (match) begin
            pred_d = step_pred;
            good_d = good_cnt + 1'b1;
            if (lock_hit) bad_d = '0;
          end else if (well_formed) begin
            pred_d = step_seed;
            good_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: once locked the prediction never reseeds from the line.
          pred_d     = step_pred;
          sample_inc = 1'b1;
          if (match) begin
            bad_d = '0;
          end else begin
            err_d   = 1'b1;
            err_inc = 1'b1;
            bad_d   = bad_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      pred      <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      pred      <= pred_d;
      good_cnt  <= good_d;
      bad_cnt   <= bad_d;
      err_pulse <= err_d;
    end
  end

  assign locked = (state == LOCKED);

  sat_counter #(.W(ERR_W)) u_err_count (
    .clk   (clk),
    .init  (init),
    .inc   (err_inc),
    .clr   (clr_cnt),
    .count (err_count)
  );

  sat_counter #(.W(ERR_W)) u_sample_count (
    .clk   (clk),
    .init  (init),
    .inc   (sample_inc),
    .clr   (clr_cnt),
    .count (sample_count)
  );

endmodule

// File: tb/tb_randn_checker.sv
// Self-checking bench for randn_checker: directed scenarios plus randomized traffic
// compared cycle by cycle against a sample-level behavioural model.
module tb_randn_checker;

  localparam int N    = 4;
  localparam int BUF  = 8;
  localparam int LC   = 4;
  localparam int LT   = 2;
  localparam int EW   = 16;
  localparam int POLY = 4'b0011;

  typedef enum int {M_HUNT, M_ACQ, M_LOCK} mstate_t;

  logic           clk = 1'b0;
  logic           init, en, clr_cnt;
  logic [N-1:0]   poly;
  logic [BUF-1:0] d;
  logic           locked, err_pulse;
  logic [EW-1:0]  err_count, sample_count;

  int checks   = 0;
  int failures = 0;

  mstate_t m_state;
  int      m_pred, m_good, m_bad, m_err, m_samp;
  bit      m_pulse;
  int      g_state;

  randn_checker #(
    .n(N), .buffer_size(BUF), .LOCK_COUNT(LC), .LOSS_THRESH(LT), .ERR_W(EW)
  ) dut (
    .clk          (clk),
    .init         (init),
    .en           (en),
    .poly         (poly),
    .D            (d),
    .clr_cnt      (clr_cnt),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Galois LFSR written as a right shift with conditional XOR of the tap mask.
  function automatic int mstep(input int s);
    int taps;
    taps = (POLY & ((1 << (N-1)) - 1)) | (1 << (N-1));
    return (s & 1) ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

  function automatic int mext(input int s);
    return (s & (1 << (N-1))) ? (s + (1 << BUF) - (1 << N)) : s;
  endfunction

  function automatic logic [BUF-1:0] gen_next();
    logic [BUF-1:0] v;
    v = BUF'(mext(g_state));
    g_state = mstep(g_state);
    return v;
  endfunction

  task automatic model_reset();
    m_state = M_HUNT; m_pred = 0; m_good = 0; m_bad = 0;
    m_err = 0; m_samp = 0; m_pulse = 1'b0;
  endtask

  task automatic model_edge(input bit e, input logic [BUF-1:0] dv, input bit c);
    int  di, low;
    bit  wf, mt;
    di = int'(dv);
    low = di & ((1 << N) - 1);
    wf = (di == mext(low)) && (low != 0);
    mt = (di == mext(m_pred));
    m_pulse = 1'b0;
    if (e) begin
      case (m_state)
        M_HUNT: if (wf) begin m_pred = mstep(low); m_good = 0; m_state = M_ACQ; end
        M_ACQ: begin
          if (mt) begin
            m_pred = mstep(m_pred);
            m_good++;
            if (m_good == LC) begin m_state = M_LOCK; m_bad = 0; end
          end else if (wf) begin
            m_pred = mstep(low); m_good = 0;
          end else begin
            m_state = M_HUNT;
          end
        end
        default: begin
          m_pred = mstep(m_pred);
          if (m_samp < (1 << EW) - 1) m_samp++;
          if (mt) m_bad = 0;
          else begin
            m_pulse = 1'b1;
            if (m_err < (1 << EW) - 1) m_err++;
            m_bad++;
            if (m_bad == LT) m_state = M_HUNT;
          end
        end
      endcase
    end
    if (c) begin m_err = 0; m_samp = 0; end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".locked"},    32'(locked),       32'(m_state == M_LOCK));
    check({tag, ".err_pulse"}, 32'(err_pulse),    32'(m_pulse));
    check({tag, ".err_count"}, 32'(err_count),    32'(m_err));
    check({tag, ".samples"},   32'(sample_count), 32'(m_samp));
  endtask

  // Called at a falling edge: drive, take one rising edge, sample at the next falling edge.
  task automatic cycle(input bit e, input logic [BUF-1:0] dv, input bit c, input string tag);
    en = e; d = dv; clr_cnt = c;
    @(posedge clk);
    model_edge(e, dv, c);
    @(negedge clk);
    compare_all(tag);
  endtask

  initial begin
    int err_before, bubbles, r;
    logic [BUF-1:0] s;
    bit e, c;

    init = 1'b1; en = 1'b0; d = '0; clr_cnt = 1'b0; poly = N'(POLY);
    model_reset();
    #3;
    check("rst.locked",    32'(locked),       32'd0);
    check("rst.err_pulse", 32'(err_pulse),    32'd0);
    check("rst.err_count", 32'(err_count),    32'd0);
    check("rst.samples",   32'(sample_count), 32'd0);
    @(negedge clk);
    init = 1'b0;

    // Acquire and lock on the clean stream 01, FB, FE, 07, ...
    g_state = 1;
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, gen_next(), 1'b0, "acq");
      if (k == 4) check("acq.not_yet", 32'(locked), 32'd0);
    end
    check("acq.locked", 32'(locked), 32'd1);
    for (int k = 0; k < 3; k++) cycle(1'b1, gen_next(), 1'b0, "acq_run");
    check("acq.samples", 32'(sample_count), 32'd3);
    check("acq.errs",    32'(err_count),    32'd0);

    // Single corrupted sample: one pulse, lock held, flywheel keeps predicting.
    cycle(1'b1, gen_next() ^ 8'h02, 1'b0, "single");
    check("single.pulse",  32'(err_pulse), 32'd1);
    check("single.errs",   32'(err_count), 32'd1);
    check("single.locked", 32'(locked),    32'd1);
    cycle(1'b1, gen_next(), 1'b0, "single_after");
    check("single.next_ok", 32'(err_pulse), 32'd0);
    check("single.locked2", 32'(locked),    32'd1);

    // Clear, then two consecutive errors drop lock; re-lock after five clean samples.
    cycle(1'b1, gen_next(), 1'b1, "clr");
    check("clr.errs",    32'(err_count),    32'd0);
    check("clr.samples", 32'(sample_count), 32'd0);
    cycle(1'b1, gen_next() ^ 8'h04, 1'b0, "loss1");
    check("loss1.locked", 32'(locked), 32'd1);
    cycle(1'b1, gen_next() ^ 8'h04, 1'b0, "loss2");
    check("loss2.pulse",  32'(err_pulse), 32'd1);
    check("loss2.errs",   32'(err_count), 32'd2);
    check("loss2.locked", 32'(locked),    32'd0);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, gen_next(), 1'b0, "relock");
      if (k == 4) check("relock.not_yet", 32'(locked), 32'd0);
    end
    check("relock.locked", 32'(locked), 32'd1);

    // en bubbles hold everything; clr_cnt wins over an increment on the same edge.
    err_before = int'(err_count);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, gen_next(), 1'b0, "gap_on");
      bubbles = $urandom_range(1, 3);
      for (int b = 0; b < bubbles; b++) begin
        cycle(1'b0, BUF'($urandom_range(0, 255)), 1'b0, "gap_off");
        check("gap.pulse", 32'(err_pulse), 32'd0);
      end
    end
    check("gap.locked", 32'(locked),    32'd1);
    check("gap.errs",   32'(err_count), 32'(err_before));
    cycle(1'b1, gen_next() ^ 8'h10, 1'b1, "clr_err");
    check("clr_err.errs",  32'(err_count), 32'd0);
    check("clr_err.pulse", 32'(err_pulse), 32'd1);

    // Asynchronous init between edges while err_pulse is high.
    en = 1'b1; d = gen_next() ^ 8'h01; clr_cnt = 1'b0;
    @(posedge clk);
    model_edge(1'b1, d, 1'b0);
    #1;
    check("pre_init.pulse", 32'(err_pulse), 32'd1);
    #1 init = 1'b1;
    #1;
    check("ainit.locked",    32'(locked),       32'd0);
    check("ainit.err_pulse", 32'(err_pulse),    32'd0);
    check("ainit.err_count", 32'(err_count),    32'd0);
    check("ainit.samples",   32'(sample_count), 32'd0);
    model_reset();
    @(negedge clk);
    init = 1'b0; en = 1'b0;

    // Bad seeds are rejected in HUNT; a good seed then needs four matches.
    cycle(1'b1, 8'h00, 1'b0, "seed00");
    cycle(1'b1, 8'h41, 1'b0, "seed41");
    check("seed.locked", 32'(locked), 32'd0);
    g_state = 1;
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b1, gen_next(), 1'b0, "seed_ok");
      if (k == 4) check("seed_ok.not_yet", 32'(locked), 32'd0);
    end
    check("seed_ok.locked", 32'(locked), 32'd1);

    // Randomized traffic: gaps, corruption, garbage and clears against the model.
    for (int k = 0; k < 600; k++) begin
      e = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 19) == 0);
      s = '0;
      if (e) begin
        r = $urandom_range(0, 99);
        s = gen_next();
        if (r < 8)       s = s ^ BUF'(1 << $urandom_range(0, BUF-1));
        else if (r < 11) s = BUF'($urandom_range(0, 255));
      end else begin
        s = BUF'($urandom_range(0, 255));
      end
      cycle(e, s, c, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
